// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Imported by the datapath step and the top-level FSM.
package multdiv_pkg;

    localparam int XLEN = 32;
    localparam int ITER = XLEN;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

endpackage

// File: rtl/multdiv_step.sv
// One shift-add (multiply) or restoring-subtract (divide) iteration.
// Works on magnitudes; sign handling lives in the top level.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  op_t            op,
    input  logic [2*W-1:0] acc,
    input  logic [W-1:0]   operand,
    output logic [2*W-1:0] acc_next,
    output logic           q_bit
);

    logic [W:0] sum;
    logic [W:0] shl_hi;
    logic [W:0] trial;

    always_comb begin
        sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
        shl_hi   = acc[2*W-1:W-1];
        trial    = shl_hi - {1'b0, operand};
        acc_next = '0;
        q_bit    = 1'b0;
        unique case (op)
            OP_MULT: begin
                q_bit    = acc[0];
                acc_next = {sum, acc[W-1:1]};
            end
            OP_DIV: begin
                // remainder always stays below the divisor, so W bits suffice
                q_bit    = ~trial[W];
                acc_next = {(q_bit ? trial[W-1:0] : shl_hi[W-1:0]),
                            acc[W-2:0], 1'b0};
            end
            default: begin
                acc_next = acc;
            end
        endcase
    end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiply/divide for the execute stage.
// Start pulse in, fixed WIDTH iterations, one-cycle ready pulse out.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int CW = $clog2(ITER);

    state_t           state;
    state_t           state_d;
    op_t              op_q;
    logic [CW-1:0]    cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] opnd;
    logic             neg;
    logic             div_zero;
    logic             div_ovf;
    logic             q_bit;
    logic             start;
    logic             last;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] res_d;
    logic             exc_d;

    assign start = ctrl_MULT | ctrl_DIV;
    assign last  = (cnt == CW'(ITER - 1));
    assign mag_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign mag_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    multdiv_step #(.W(WIDTH)) u_step (
        .op       (op_q),
        .acc      (acc),
        .operand  (opnd),
        .acc_next (acc_step),
        .q_bit    (q_bit)
    );

    always_comb begin
        acc_d = {acc_step[2*WIDTH-1:1],
                 (op_q == OP_DIV) ? q_bit : acc_step[0]};
        prod  = neg ? -acc_d : acc_d;
        quot  = neg ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
        res_d = '0;
        exc_d = 1'b0;
        unique case (op_q)
            OP_MULT: begin
                res_d = prod[WIDTH-1:0];
                exc_d = prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}};
            end
            OP_DIV: begin
                res_d = div_zero ? '0 : quot;
                exc_d = div_zero | div_ovf;
            end
            default: begin
                res_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d        = state;
        data_resultRDY = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (start)     state_d = RUN;
                else if (last) state_d = DONE;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                state_d        = start ? RUN : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            op_q           <= OP_MULT;
            cnt            <= '0;
            acc            <= '0;
            opnd           <= '0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start) begin
            op_q     <= ctrl_MULT ? OP_MULT : OP_DIV;
            cnt      <= '0;
            neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == INT_MIN) && (data_operandB == '1);
            if (ctrl_MULT) begin
                acc  <= {{WIDTH{1'b0}}, mag_b};
                opnd <= mag_a;
            end else begin
                acc  <= {{WIDTH{1'b0}}, mag_a};
                opnd <= mag_b;
            end
        end else if (state == RUN) begin
            acc <= acc_d;
            cnt <= cnt + 1'b1;
            if (last) begin
                data_result    <= res_d;
                data_exception <= exc_d;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and random checks of multdiv_unit against an arithmetic model.
// Covers latency, ready pulse width, exceptions, restart and async reset.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int checks = 0;
    int errors = 0;

    multdiv_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .resetn         (resetn),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [32:0] model(input bit is_div,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        int q;
        logic [31:0] r;
        if (!is_div) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            return {(p != longint'($signed(r))), r};
        end
        if (b == 0) return {1'b1, 32'h0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return {1'b1, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        return {1'b0, q};
    endfunction

    task automatic drive_start(input bit is_div, input logic [31:0] a,
                               input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = !is_div;
        ctrl_DIV = is_div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_rdy(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input bit is_div,
                          input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [32:0] exp;
        exp = model(is_div, a, b);
        drive_start(is_div, a, b);
        wait_rdy(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd32);
        chk({tag, "_res"}, 64'(data_result), 64'(exp[31:0]));
        chk({tag, "_exc"}, 64'(data_exception), 64'(exp[32]));
    endtask

    initial begin
        int lat;
        int pulses;
        bit d;
        logic [31:0] a;
        logic [31:0] b;

        #12;
        chk("rst_res", 64'(data_result), 64'd0);
        chk("rst_exc", 64'(data_exception), 64'd0);
        chk("rst_rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        resetn = 1'b1;

        run_op("mul_7x-6", 1'b0, 32'd7, -32'sd6);
        chk("mul_7x-6_val", 64'(data_result), 64'h0000_0000_FFFF_FFD6);
        @(posedge clock);
        #1;
        chk("rdy_one_cycle", 64'(data_resultRDY), 64'd0);
        chk("res_held", 64'(data_result), 64'h0000_0000_FFFF_FFD6);

        run_op("mul_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000);
        chk("mul_ovf_exc", 64'(data_exception), 64'd1);
        run_op("mul_max", 1'b0, 32'h7FFF_FFFF, 32'd1);
        run_op("mul_min", 1'b0, 32'h8000_0000, 32'd1);
        run_op("mul_minx-1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_-17/5", 1'b1, -32'sd17, 32'd5);
        chk("div_-17/5_val", 64'(data_result), 64'h0000_0000_FFFF_FFFD);
        run_op("div_by0", 1'b1, 32'd100, 32'd0);
        chk("div_by0_exc", 64'(data_exception), 64'd1);
        run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_min/1", 1'b1, 32'h8000_0000, 32'd1);
        run_op("div_7/-2", 1'b1, 32'd7, -32'sd2);

        for (int i = 0; i < 16; i++) begin
            d = i[0];
            a = $urandom;
            b = $urandom;
            if (i % 4 == 2) b = $urandom_range(0, 9) - 32'd4;
            if (i % 4 == 3) a = $urandom_range(0, 2000) - 32'd1000;
            run_op($sformatf("rnd%0d", i), d, a, b);
        end

        drive_start(1'b0, 32'd3, 32'd4);
        pulses = 0;
        for (int k = 0; k < 9; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        drive_start(1'b1, 32'd20, 32'd4);
        wait_rdy(lat);
        chk("restart_early_rdy", 64'(pulses), 64'd0);
        chk("restart_lat", 64'(lat), 64'd32);
        chk("restart_res", 64'(data_result), 64'd5);
        chk("restart_exc", 64'(data_exception), 64'd0);

        drive_start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (5) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_res", 64'(data_result), 64'd0);
        chk("midrst_exc", 64'(data_exception), 64'd0);
        chk("midrst_rdy", 64'(data_resultRDY), 64'd0);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) pulses++;
        end
        chk("midrst_no_rdy", 64'(pulses), 64'd0);
        run_op("post_rst", 1'b0, 32'd2, 32'd3);
        chk("post_rst_val", 64'(data_result), 64'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
